idct8x8_serial: RTL and testbench

Inverse 2D 8x8 DCT for the image pipeline's decode path, the counterpart of the forward DCT encoder.
- Accepts one 64-coefficient block in row-major order over a valid/ready stream.
- Performs row and column 1D IDCT passes with a single shared multiply-accumulate unit.
- Streams 64 reconstructed 8-bit pixels, row-major, over a second valid/ready stream.
- Resource-light, not throughput-oriented: one block in flight, no overlap of load, compute and drain.

---
 rtl/idct8x8_serial.sv | 263 ++++++++++++++++++++++++++
 tb/tb_idct8x8_serial.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct8x8_serial.sv
// ---------------------------------------------------------------------------
// idct8x8_serial
//   Inverse 2D 8x8 DCT for the decode path, built around one shared
//   multiply-accumulate unit. One block is handled at a time:
//   load, row pass, column pass, drain.
//
//   Ports
//     clk        clock
//     rst        synchronous, active-high reset
//     in_valid   coefficient valid
//     in_ready   coefficient accepted (high only while loading)
//     in_data    signed coefficient F[v][u], row-major (index v*8+u)
//     out_valid  pixel valid
//     out_ready  downstream accepts the pixel
//     out_data   unsigned 8-bit pixel p[y][x], row-major (index y*8+x)
//     out_last   marks the 64th pixel of a block
//
//   Pipeline: each pass step launches one MAC term (registered RAM/ROM
//   reads). The following cycle accumulates it and, on the 8th term,
//   rounds and writes the result. The final term of a pass therefore
//   lands in the extra flush step (step 512) of that pass.
// ---------------------------------------------------------------------------
module idct8x8_serial #(
    parameter int IN_W  = 15,
    parameter int TMP_W = 16,
    parameter int CF_W  = 13
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            out_last
);

    localparam int ACC_W  = 34;
    localparam int PROD_W = CF_W + TMP_W;
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2048);
    localparam logic signed [ACC_W-1:0] PIX_BIAS = ACC_W'(128);

    typedef enum logic [1:0] {LOAD, ROW, COL, OUT} state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;     // load index in LOAD, drain index in OUT
    logic [9:0]  step_reg, step_next;   // 0..511 issue steps, 512 = flush
    logic        in_ready_reg, out_valid_reg;
    logic [7:0]  out_data_reg;

    logic in_hs, out_hs;
    assign in_hs  = in_ready_reg && in_valid;
    assign out_hs = out_valid_reg && out_ready;

    // ------------------------------------------------------------------
    // Cosine ROM, Q1.12: C[u][x] = round(4096*a(u)*cos((2x+1)u*pi/16))
    // ------------------------------------------------------------------
    function automatic logic signed [CF_W-1:0] cos_q12(input int u, input int x);
        int k;
        int mag;
        logic neg;
        logic signed [CF_W-1:0] val;
        if (u == 0) begin
            return CF_W'(1448);
        end
        // Fold the angle k*pi/16 into the first quadrant.
        k   = ((2 * x + 1) * u) % 32;
        neg = 1'b0;
        if (k > 16) k = 32 - k;
        if (k > 8) begin
            k   = 16 - k;
            neg = 1'b1;
        end
        case (k)
            0:       mag = 2048;
            1:       mag = 2009;
            2:       mag = 1892;
            3:       mag = 1703;
            4:       mag = 1448;
            5:       mag = 1138;
            6:       mag = 784;
            7:       mag = 400;
            default: mag = 0;
        endcase
        val = CF_W'(mag);
        return neg ? -val : val;
    endfunction

    logic signed [CF_W-1:0] cos_rom [64];
    for (genvar gi = 0; gi < 64; gi++) begin : g_cos_rom
        assign cos_rom[gi] = cos_q12(gi / 8, gi % 8);
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic signed [IN_W-1:0]  coef_ram [64];
    logic signed [TMP_W-1:0] tmp_ram  [64];
    logic [7:0]              pix_ram  [64];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= LOAD;
            cnt_reg       <= 6'd0;
            step_reg      <= 10'd0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            step_reg      <= step_next;
            in_ready_reg  <= (state_next == LOAD);
            out_valid_reg <= (state_next == OUT);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        step_next  = step_reg;
        case (state_reg)
            LOAD: begin
                if (in_hs) begin
                    cnt_next = cnt_reg + 6'd1;
                    if (cnt_reg == 6'd63) state_next = ROW;
                end
            end
            ROW: begin
                if (step_reg[9]) begin
                    step_next  = 10'd0;
                    state_next = COL;
                end else begin
                    step_next = step_reg + 10'd1;
                end
            end
            COL: begin
                if (step_reg[9]) begin
                    step_next  = 10'd0;
                    state_next = OUT;
                end else begin
                    step_next = step_reg + 10'd1;
                end
            end
            OUT: begin
                if (out_hs) begin
                    cnt_next = cnt_reg + 6'd1;
                    if (cnt_reg == 6'd63) state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Issue stage: step = output_index*8 + term
    //   ROW: out o = v*8+x, term u -> F[v][u], C[u][x]
    //   COL: out o = y*8+x, term v -> tmp[v][x], C[v][y]
    // ------------------------------------------------------------------
    logic       issue;
    logic [5:0] o_idx;
    logic [2:0] t_idx;
    logic [5:0] coef_rd_addr, tmp_rd_addr, rom_addr;

    assign o_idx        = step_reg[8:3];
    assign t_idx        = step_reg[2:0];
    assign issue        = ((state_reg == ROW) || (state_reg == COL)) && !step_reg[9];
    assign coef_rd_addr = {o_idx[5:3], t_idx};
    assign tmp_rd_addr  = {t_idx, o_idx[2:0]};
    assign rom_addr     = (state_reg == COL) ? {t_idx, o_idx[5:3]} : {t_idx, o_idx[2:0]};

    logic signed [IN_W-1:0]  coef_q_reg;
    logic signed [TMP_W-1:0] tmp_q_reg;
    logic signed [CF_W-1:0]  cos_q_reg;
    logic                    mac_valid_reg, mac_first_reg, mac_last_reg, mac_col_reg;
    logic [5:0]              mac_addr_reg;

    always_ff @(posedge clk) begin
        if (in_hs) coef_ram[cnt_reg] <= in_data;
        coef_q_reg <= coef_ram[coef_rd_addr];
    end

    always_ff @(posedge clk) begin
        cos_q_reg    <= cos_rom[rom_addr];
        mac_first_reg <= (t_idx == 3'd0);
        mac_last_reg  <= (t_idx == 3'd7);
        mac_col_reg   <= (state_reg == COL);
        mac_addr_reg  <= o_idx;
        if (rst) mac_valid_reg <= 1'b0;
        else     mac_valid_reg <= issue;
    end

    // ------------------------------------------------------------------
    // MAC stage
    // ------------------------------------------------------------------
    logic signed [TMP_W-1:0]  mul_b;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext, acc_reg, acc_sum, acc_rnd, acc_shr, pix_val;
    logic signed [TMP_W-1:0]  tmp_sat;
    logic [7:0]               pix_clamp;

    assign mul_b    = mac_col_reg ? tmp_q_reg
                                  : {{(TMP_W-IN_W){coef_q_reg[IN_W-1]}}, coef_q_reg};
    assign prod     = cos_q_reg * mul_b;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign acc_sum  = (mac_first_reg ? '0 : acc_reg) + prod_ext;
    assign acc_rnd  = acc_sum + RND_HALF;
    assign acc_shr  = acc_rnd >>> 12;
    assign pix_val  = acc_shr + PIX_BIAS;

    // Row result saturates when the bits above the TMP_W sign bit disagree.
    always_comb begin
        tmp_sat = acc_shr[TMP_W-1:0];
        if (acc_shr[ACC_W-1:TMP_W-1] != {(ACC_W-TMP_W+1){acc_shr[ACC_W-1]}}) begin
            tmp_sat = acc_shr[ACC_W-1] ? {1'b1, {(TMP_W-1){1'b0}}}
                                       : {1'b0, {(TMP_W-1){1'b1}}};
        end
    end

    always_comb begin
        pix_clamp = pix_val[7:0];
        if (pix_val[ACC_W-1])           pix_clamp = 8'd0;
        else if (|pix_val[ACC_W-2:8])   pix_clamp = 8'd255;
    end

    always_ff @(posedge clk) begin
        if (mac_valid_reg) acc_reg <= acc_sum;
    end

    always_ff @(posedge clk) begin
        if (mac_valid_reg && mac_last_reg && !mac_col_reg) tmp_ram[mac_addr_reg] <= tmp_sat;
        tmp_q_reg <= tmp_ram[tmp_rd_addr];
    end

    // ------------------------------------------------------------------
    // Pixel RAM and output register. Pixel 0 is prefetched during the
    // column flush step; each output handshake fetches the next pixel,
    // so out_data holds while the consumer stalls.
    // ------------------------------------------------------------------
    logic [5:0] pix_rd_addr;
    logic       pix_rd_en;

    assign pix_rd_addr = (state_reg == OUT) ? (cnt_reg + 6'd1) : 6'd0;
    assign pix_rd_en   = ((state_reg == COL) && step_reg[9]) || out_hs;

    always_ff @(posedge clk) begin
        if (mac_valid_reg && mac_last_reg && mac_col_reg) pix_ram[mac_addr_reg] <= pix_clamp;
    end

    always_ff @(posedge clk) begin
        if (rst)            out_data_reg <= 8'd0;
        else if (pix_rd_en) out_data_reg <= pix_ram[pix_rd_addr];
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_valid_reg && (cnt_reg == 6'd63);

endmodule

// File: tb/tb_idct8x8_serial.sv
// ---------------------------------------------------------------------------
// tb_idct8x8_serial
//   Directed sequence of blocks against idct8x8_serial. Expected pixels are
//   pushed to a scoreboard queue when a block is sent and popped on each
//   output handshake.
// ---------------------------------------------------------------------------
module tb_idct8x8_serial;

    localparam int  IN_W = 15;
    localparam real PI   = 3.14159265358979323846;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IN_W-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [7:0]      out_data;
    logic            out_last;

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    longint      t_last_in = 0;
    int          cos_tab [8][8];
    int          coef [64];
    logic [7:0]  exp_q [$];

    idct8x8_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input longint obs, input longint exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int rnd(input real r);
        return $rtoi($floor(r + 0.5));
    endfunction

    // Bit-exact fixed-point reference of both passes.
    task automatic model_block();
        longint t [64];
        longint acc;
        for (int v = 0; v < 8; v++)
            for (int x = 0; x < 8; x++) begin
                acc = 0;
                for (int u = 0; u < 8; u++)
                    acc += longint'(cos_tab[u][x]) * longint'(coef[v*8+u]);
                acc = (acc + 2048) >>> 12;
                if (acc > 32767)  acc = 32767;
                if (acc < -32768) acc = -32768;
                t[v*8+x] = acc;
            end
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                acc = 0;
                for (int v = 0; v < 8; v++)
                    acc += longint'(cos_tab[v][y]) * t[v*8+x];
                acc = ((acc + 2048) >>> 12) + 128;
                if (acc < 0)   acc = 0;
                if (acc > 255) acc = 255;
                exp_q.push_back(8'(acc));
            end
    endtask

    task automatic push_const(input int p);
        for (int i = 0; i < 64; i++) exp_q.push_back(8'(p));
    endtask

    task automatic set_dc(input int dc);
        for (int i = 0; i < 64; i++) coef[i] = 0;
        coef[0] = dc;
    endtask

    task automatic send_block(input bit gaps);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < 64 && guard < 4000) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = IN_W'(coef[idx]);
            if (in_valid && in_ready) begin
                if (idx == 63) t_last_in = cyc;
                idx++;
            end
            tick();
            guard++;
        end
        in_valid = 1'b0;
        check("load_count", idx, 64);
        check("in_ready_after_load", in_ready, 0);
        $display("send: block loaded at cycle %0d", t_last_in);
    endtask

    task automatic recv_block(input bit rand_ready, input bit tol);
        int beat;
        int guard;
        int exp_v;
        int diff;
        bit first;
        beat = 0;
        guard = 0;
        first = 1'b1;
        while (beat < 64 && guard < 8000) begin
            out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (out_valid) begin
                if (first) begin
                    first = 1'b0;
                    check("latency", cyc - t_last_in, 1027);
                end
                exp_v = int'(exp_q[0]);
                if (tol) begin
                    diff = int'(out_data) - exp_v;
                    checks++;
                    assert (diff >= -1 && diff <= 1) else begin
                        errors++;
                        $error("FAIL roundtrip beat %0d: observed %0d expected %0d +/-1", beat, out_data, exp_v);
                    end
                end else begin
                    check("pixel", out_data, exp_v);
                end
                check("out_last", out_last, (beat == 63));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    beat++;
                end
            end else if (!first) begin
                check("out_valid_held", out_valid, 1);
            end
            tick();
            guard++;
        end
        out_ready = 1'b0;
        check("beat_count", beat, 64);
        check("out_valid_after_last", out_valid, 0);
        check("in_ready_after_last", in_ready, 1);
        $display("recv: %0d pixels drained by cycle %0d", beat, cyc);
    endtask

    initial begin
        real pix_r [64];
        real s;
        real av, au;

        for (int u = 0; u < 8; u++)
            for (int x = 0; x < 8; x++)
                cos_tab[u][x] = (u == 0) ? 1448
                              : rnd(2048.0 * $cos(real'((2*x+1)*u) * PI / 16.0));

        // Reset values
        rst = 1'b1;
        tick(); tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        rst = 1'b0;
        tick();
        check("in_ready_after_rst", in_ready, 1);

        // All-zero block
        set_dc(0);
        push_const(128);
        send_block(1'b0);
        recv_block(1'b0, 1'b0);

        // DC only, back-to-back with the previous block
        set_dc(80);
        push_const(138);
        send_block(1'b0);
        recv_block(1'b0, 1'b0);

        // Clamp high and low
        set_dc(2000);
        push_const(255);
        send_block(1'b0);
        recv_block(1'b1, 1'b0);
        set_dc(-2000);
        push_const(0);
        send_block(1'b1);
        recv_block(1'b1, 1'b0);

        // Random moderate coefficients
        for (int i = 0; i < 64; i++) coef[i] = int'($urandom_range(0, 1023)) - 512;
        model_block();
        send_block(1'b1);
        recv_block(1'b1, 1'b0);

        // Random full-range coefficients (exercises row saturation)
        for (int i = 0; i < 64; i++) coef[i] = int'($urandom_range(0, 32767)) - 16384;
        model_block();
        send_block(1'b1);
        recv_block(1'b1, 1'b0);

        // Round trip through a double-precision forward DCT
        for (int i = 0; i < 64; i++) begin
            pix_r[i] = real'($urandom_range(0, 255));
            exp_q.push_back(8'($rtoi(pix_r[i])));
        end
        for (int v = 0; v < 8; v++)
            for (int u = 0; u < 8; u++) begin
                s = 0.0;
                for (int y = 0; y < 8; y++)
                    for (int x = 0; x < 8; x++)
                        s += (pix_r[y*8+x] - 128.0)
                             * $cos(real'((2*y+1)*v) * PI / 16.0)
                             * $cos(real'((2*x+1)*u) * PI / 16.0);
                av = (v == 0) ? $sqrt(0.125) : 0.5;
                au = (u == 0) ? $sqrt(0.125) : 0.5;
                coef[v*8+u] = rnd(av * au * s);
            end
        send_block(1'b0);
        recv_block(1'b1, 1'b1);

        // Reset in the middle of the column pass, then a fresh DC block
        for (int i = 0; i < 64; i++) coef[i] = int'($urandom_range(0, 2047)) - 1024;
        send_block(1'b0);
        while (cyc < t_last_in + 700) tick();
        rst = 1'b1;
        tick();
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        check("abort_out_last", out_last, 0);
        rst = 1'b0;
        tick();
        check("abort_in_ready_back", in_ready, 1);
        exp_q.delete();
        set_dc(80);
        push_const(138);
        send_block(1'b0);
        recv_block(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
